// File: rtl/ysyx_25040129_ifu_pkg.sv
// Shared definitions for the multi-cycle instruction fetch unit.
//   ifu_state_e      : fetch FSM states
//   INST_NOP         : instruction presented when nothing valid is held or on a fault
//   RESET_PC_DEFAULT : default first fetch address after reset
//   is_misaligned()  : true when a PC is not word aligned
package ysyx_25040129_ifu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } ifu_state_e;

  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  function automatic logic is_misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_25040129_ifu_timeout.sv
// Response timeout counter for the fetch unit.
// Ports:
//   clk, rst : clock, synchronous active-low reset
//   clear    : force the count back to zero (takes priority over enable)
//   enable   : count one cycle of waiting
//   expired  : high in the waiting cycle whose count equals TIMEOUT-1
module ysyx_25040129_ifu_timeout #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = $clog2(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign expired = enable && (count_reg == LAST);

endmodule

// File: rtl/ysyx_25040129_fetch_unit.sv
// Multi-cycle instruction fetch stage. One request at a time goes out on a
// valid/ready imem port; the fetched word is held on a valid/ready port to IDU.
// Sequential PC (+4) unless a redirect supplies a new PC.
// Ports:
//   clk, rst                       : clock, synchronous active-low reset
//   redirect_valid, redirect_pc    : replace fetch PC (branch/jump/trap)
//   imem_req_valid/ready/addr      : fetch request channel (addr = current PC)
//   imem_rsp_valid/data/err        : one-cycle response strobe with data and error
//   out_valid/ready, out_pc/inst   : instruction handed to IDU
//   out_fault                      : rsp error, timeout or misaligned redirect
//   perf_fetch_cnt, perf_stall_cnt : only when IFU_PERF_CNT_EN is defined; count
//                                    out handshakes and cycles in S_WAIT/S_DRAIN
module ysyx_25040129_fetch_unit
  import ysyx_25040129_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_fault
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  ifu_state_e  state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] inst_reg, inst_next;
  logic        fault_reg, fault_next;
  logic        stale_reg, stale_next;

  logic req_fire;
  logic in_wait;
  logic timer_clear;
  logic timer_expired;
  logic outstanding;

  assign imem_req_valid = (state_reg == S_REQ) && !stale_reg;
  assign imem_req_addr  = pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign in_wait        = (state_reg == S_WAIT) || (state_reg == S_DRAIN);

  assign out_valid = (state_reg == S_HOLD);
  assign out_pc    = pc_reg;
  assign out_inst  = out_valid ? inst_reg : INST_NOP;
  assign out_fault = out_valid && fault_reg;

  // A request is still owed a response if it is accepted this cycle, or if we
  // are waiting and neither the response nor the timeout happens this cycle.
  assign outstanding = req_fire || (in_wait && !imem_rsp_valid && !timer_expired);

  // Fresh timeout window on every entry into S_WAIT or S_DRAIN.
  assign timer_clear = !in_wait || (state_next != state_reg);

  ysyx_25040129_ifu_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (in_wait),
    .expired(timer_expired)
  );

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    inst_next  = inst_reg;
    fault_next = fault_reg;
    stale_next = stale_reg;

    // Any response we are not waiting for is the late one a timeout gave up on.
    if (imem_rsp_valid && (state_reg != S_WAIT)) begin
      stale_next = 1'b0;
    end

    case (state_reg)
      S_IDLE: state_next = S_REQ;
      S_REQ: begin
        if (req_fire) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          inst_next  = imem_rsp_data;
          fault_next = imem_rsp_err;
          state_next = S_HOLD;
        end else if (timer_expired) begin
          inst_next  = INST_NOP;
          fault_next = 1'b1;
          stale_next = 1'b1;
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          pc_next    = pc_reg + 32'd4;
          state_next = S_REQ;
        end
      end
      S_DRAIN: begin
        if (imem_rsp_valid) begin
          state_next = S_REQ;
        end else if (timer_expired) begin
          stale_next = 1'b1;
          state_next = S_REQ;
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (redirect_valid) begin
      pc_next = redirect_pc;
      if (is_misaligned(redirect_pc)) begin
        inst_next  = INST_NOP;
        fault_next = 1'b1;
        state_next = S_HOLD;
        // Skipping S_DRAIN would let the owed response be taken for a later
        // request, so mark it stale instead.
        if (outstanding) stale_next = 1'b1;
      end else if (outstanding) begin
        state_next = S_DRAIN;
      end else begin
        // Includes a response arriving in the same cycle as the redirect:
        // it is simply dropped and nothing is left to drain.
        state_next = S_REQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      pc_reg    <= RESET_PC;
      inst_reg  <= INST_NOP;
      fault_reg <= 1'b0;
      stale_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      inst_reg  <= inst_next;
      fault_reg <= fault_next;
      stale_reg <= stale_next;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_reg;
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_cnt_reg <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (out_valid && out_ready) fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
      if (in_wait) stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_reg;
  assign perf_stall_cnt = stall_cnt_reg;
`endif

endmodule
